// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor resolve path.
// Entry layout mirrors what fetch knows about an in-flight predicted branch.
package bp_pkg;

    localparam int BP_IDX_W = 10;
    localparam int BP_TGT_W = 30;

    localparam logic [15:0] CNT_SAT = 16'hFFFF;

    typedef struct packed {
        logic [BP_IDX_W-1:0] idx;
        logic                taken;
        logic [BP_TGT_W-1:0] target;
        logic [BP_TGT_W-1:0] fallthru;
    } bp_entry_t;

endpackage

// File: rtl/bru_fifo.sv
// In-order tracking queue of predicted branches; head visible combinationally, 1-cycle write-to-read.
// Push while full is accepted only with a same-cycle pop; clear drops all entries and any push.
module bru_fifo
    import bp_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = bp_entry_t
) (
    input  logic Clk,
    input  logic Reset,
    input  logic push,
    input  T     push_dat,
    input  logic pop,
    input  logic clear,
    output T     head_dat,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // When full, the tail slot is the head being popped; the read above sees the old value.
    always_ff @(posedge Clk) begin
        if (push_ok && !clear && !Reset) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Compares the oldest tracked prediction with the EX outcome; table update and flush are registered (1 cycle).
// No backpressure: pushes beyond capacity are dropped (o_overflow), resolves on empty are ignored (o_underflow).
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = BP_IDX_W,
    parameter int TGT_W = BP_TGT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_push,
    input  logic [IDX_W-1:0] i_push_idx,
    input  logic             i_push_taken,
    input  logic [TGT_W-1:0] i_push_target,
    input  logic [TGT_W-1:0] i_push_fallthru,
    output logic             o_full,
    output logic             o_empty,
    input  logic             i_resolve,
    input  logic             i_actual_taken,
    input  logic [TGT_W-1:0] i_actual_target,
    output logic             o_WE,
    output logic [IDX_W-1:0] o_addrw,
    output logic             o_rd_steal,
    output logic             o_next,
    output logic [TGT_W-1:0] o_wdata,
    output logic             o_flush,
    output logic [TGT_W-1:0] o_redirect,
    output logic             o_overflow,
    output logic             o_underflow,
    output logic [15:0]      o_branches,
    output logic [15:0]      o_mispredicts
);

    bp_entry_t        push_entry;
    bp_entry_t        head;
    logic             q_full;
    logic             q_empty;
    logic             resolve_ok;
    logic             mispredict;
    logic [TGT_W-1:0] upd_target;
    logic [TGT_W-1:0] fix_target;

    logic             we_q;
    logic [IDX_W-1:0] addrw_q;
    logic             next_q;
    logic [TGT_W-1:0] wdata_q;
    logic             flush_q;
    logic [TGT_W-1:0] redirect_q;
    logic             overflow_q;
    logic             underflow_q;
    logic [15:0]      branches_q;
    logic [15:0]      mispredicts_q;

    always_comb begin
        push_entry          = '0;
        push_entry.idx      = i_push_idx;
        push_entry.taken    = i_push_taken;
        push_entry.target   = i_push_target;
        push_entry.fallthru = i_push_fallthru;
    end

    assign resolve_ok = i_resolve && !q_empty;
    assign mispredict = (head.taken != i_actual_taken) ||
                        (head.taken && i_actual_taken && (head.target != i_actual_target));
    // A not-taken outcome leaves the stored target untouched in the table.
    assign upd_target = i_actual_taken ? i_actual_target : head.target;
    assign fix_target = i_actual_taken ? i_actual_target : head.fallthru;

    bru_fifo #(
        .DEPTH (DEPTH),
        .T     (bp_entry_t)
    ) u_fifo (
        .Clk      (Clk),
        .Reset    (Reset),
        .push     (i_push && !(resolve_ok && mispredict)),
        .push_dat (push_entry),
        .pop      (resolve_ok),
        .clear    (resolve_ok && mispredict),
        .head_dat (head),
        .full     (q_full),
        .empty    (q_empty)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            we_q          <= 1'b0;
            addrw_q       <= '0;
            next_q        <= 1'b0;
            wdata_q       <= '0;
            flush_q       <= 1'b0;
            redirect_q    <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            we_q    <= resolve_ok;
            flush_q <= resolve_ok && mispredict;
            if (resolve_ok) begin
                addrw_q <= head.idx;
                next_q  <= i_actual_taken;
                wdata_q <= upd_target;
                if (branches_q != CNT_SAT) branches_q <= branches_q + 16'd1;
            end
            if (resolve_ok && mispredict) begin
                redirect_q <= fix_target;
                if (mispredicts_q != CNT_SAT) mispredicts_q <= mispredicts_q + 16'd1;
            end
            if (i_push && q_full && !resolve_ok) overflow_q <= 1'b1;
            if (i_resolve && q_empty)            underflow_q <= 1'b1;
        end
    end

    assign o_full        = q_full;
    assign o_empty       = q_empty;
    assign o_WE          = we_q;
    assign o_rd_steal    = we_q;
    assign o_addrw       = addrw_q;
    assign o_next        = next_q;
    assign o_wdata       = wdata_q;
    assign o_flush       = flush_q;
    assign o_redirect    = redirect_q;
    assign o_overflow    = overflow_q;
    assign o_underflow   = underflow_q;
    assign o_branches    = branches_q;
    assign o_mispredicts = mispredicts_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench: each valid resolve queues its expected table update, checked after the next edge.
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;

    typedef struct {
        logic [9:0]  idx;
        logic        taken;
        logic [29:0] target;
        logic [29:0] fallthru;
    } ent_t;

    typedef struct {
        logic        we;
        logic [9:0]  addrw;
        logic        next;
        logic [29:0] wdata;
        logic        flush;
    } upd_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        i_push;
    logic [9:0]  i_push_idx;
    logic        i_push_taken;
    logic [29:0] i_push_target;
    logic [29:0] i_push_fallthru;
    logic        o_full;
    logic        o_empty;
    logic        i_resolve;
    logic        i_actual_taken;
    logic [29:0] i_actual_target;
    logic        o_WE;
    logic [9:0]  o_addrw;
    logic        o_rd_steal;
    logic        o_next;
    logic [29:0] o_wdata;
    logic        o_flush;
    logic [29:0] o_redirect;
    logic        o_overflow;
    logic        o_underflow;
    logic [15:0] o_branches;
    logic [15:0] o_mispredicts;

    branch_resolve_unit #(.DEPTH(DEPTH), .IDX_W(10), .TGT_W(30)) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .i_push          (i_push),
        .i_push_idx      (i_push_idx),
        .i_push_taken    (i_push_taken),
        .i_push_target   (i_push_target),
        .i_push_fallthru (i_push_fallthru),
        .o_full          (o_full),
        .o_empty         (o_empty),
        .i_resolve       (i_resolve),
        .i_actual_taken  (i_actual_taken),
        .i_actual_target (i_actual_target),
        .o_WE            (o_WE),
        .o_addrw         (o_addrw),
        .o_rd_steal      (o_rd_steal),
        .o_next          (o_next),
        .o_wdata         (o_wdata),
        .o_flush         (o_flush),
        .o_redirect      (o_redirect),
        .o_overflow      (o_overflow),
        .o_underflow     (o_underflow),
        .o_branches      (o_branches),
        .o_mispredicts   (o_mispredicts)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    ent_t        mq[$];
    upd_t        sb[$];
    logic [29:0] m_redirect;
    logic        m_ovf;
    logic        m_unf;
    logic [15:0] m_br;
    logic [15:0] m_mis;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit push, input logic [9:0] idx, input bit tk,
                        input logic [29:0] tgt, input logic [29:0] ft,
                        input bit res, input bit at, input logic [29:0] atgt);
        ent_t h;
        upd_t u;
        bit   mis;
        ent_t e;
        @(negedge Clk);
        Reset           = rst;
        i_push          = push;
        i_push_idx      = idx;
        i_push_taken    = tk;
        i_push_target   = tgt;
        i_push_fallthru = ft;
        i_resolve       = res;
        i_actual_taken  = at;
        i_actual_target = atgt;
        if (rst) begin
            mq.delete();
            sb.delete();
            m_redirect = '0;
            m_ovf = 0;
            m_unf = 0;
            m_br  = '0;
            m_mis = '0;
        end else begin
            mis = 0;
            if (res && mq.size() == 0) m_unf = 1;
            if (res && mq.size() > 0) begin
                h   = mq.pop_front();
                mis = (h.taken != at) || (h.taken && at && h.target != atgt);
                u.we    = 1;
                u.addrw = idx_of(h);
                u.next  = at;
                u.wdata = at ? atgt : h.target;
                u.flush = mis;
                sb.push_back(u);
                if (m_br != 16'hFFFF) m_br++;
                if (mis) begin
                    if (m_mis != 16'hFFFF) m_mis++;
                    m_redirect = at ? atgt : h.fallthru;
                    mq.delete();
                end
            end
            if (push && !mis) begin
                if (mq.size() < DEPTH) begin
                    e.idx = idx; e.taken = tk; e.target = tgt; e.fallthru = ft;
                    mq.push_back(e);
                end else begin
                    m_ovf = 1;
                end
            end
        end
        @(posedge Clk);
        #1;
        if (sb.size() > 0) begin
            u = sb.pop_front();
            chk("we",       {31'd0, o_WE},       {31'd0, u.we});
            chk("rd_steal", {31'd0, o_rd_steal}, {31'd0, u.we});
            chk("addrw",    {22'd0, o_addrw},    {22'd0, u.addrw});
            chk("next",     {31'd0, o_next},     {31'd0, u.next});
            chk("wdata",    {2'd0, o_wdata},     {2'd0, u.wdata});
            chk("flush",    {31'd0, o_flush},    {31'd0, u.flush});
        end else begin
            chk("we_idle",    {31'd0, o_WE},    32'd0);
            chk("flush_idle", {31'd0, o_flush}, 32'd0);
        end
        chk("redirect",    {2'd0, o_redirect},   {2'd0, m_redirect});
        chk("empty",       {31'd0, o_empty},     {31'd0, mq.size() == 0});
        chk("full",        {31'd0, o_full},      {31'd0, mq.size() == DEPTH});
        chk("overflow",    {31'd0, o_overflow},  {31'd0, m_ovf});
        chk("underflow",   {31'd0, o_underflow}, {31'd0, m_unf});
        chk("branches",    {16'd0, o_branches},  {16'd0, m_br});
        chk("mispredicts", {16'd0, o_mispredicts}, {16'd0, m_mis});
    endtask

    function automatic logic [9:0] idx_of(input ent_t e);
        return e.idx;
    endfunction

    task automatic push_only(input logic [9:0] idx, input bit tk, input logic [29:0] tgt, input logic [29:0] ft);
        step(0, 1, idx, tk, tgt, ft, 0, 0, '0);
    endtask

    task automatic resolve_only(input bit at, input logic [29:0] atgt);
        step(0, 0, '0, 0, '0, '0, 1, at, atgt);
    endtask

    initial begin
        Reset = 1; i_push = 0; i_push_idx = '0; i_push_taken = 0; i_push_target = '0;
        i_push_fallthru = '0; i_resolve = 0; i_actual_taken = 0; i_actual_target = '0;

        step(1, 0, '0, 0, '0, '0, 0, 0, '0);
        step(1, 1, 10'd3, 1, 30'h10, 30'h11, 1, 1, 30'h10);
        step(0, 0, '0, 0, '0, '0, 0, 0, '0);

        // Correct taken prediction
        push_only(10'd5, 1, 30'h100, 30'h6);
        resolve_only(1, 30'h100);

        // Direction mispredict: predicted not-taken, went taken
        push_only(10'd7, 0, 30'h33, 30'h21);
        resolve_only(1, 30'h80);

        // Flush discards younger entries; following resolve underflows
        push_only(10'd1, 1, 30'h50, 30'h41);
        push_only(10'd2, 0, 30'h60, 30'h42);
        push_only(10'd3, 1, 30'h70, 30'h43);
        resolve_only(0, 30'h99);
        resolve_only(1, 30'h50);

        // Fill, overflow, then push + correct resolve while full
        for (int i = 0; i < DEPTH; i++) push_only(10'(16 + i), 0, 30'(i), 30'(32 + i));
        push_only(10'd99, 1, 30'h77, 30'h78);
        step(0, 1, 10'd40, 1, 30'h140, 30'h141, 1, 0, 30'h5);
        for (int i = 0; i < DEPTH - 1; i++) resolve_only(0, 30'h0);
        resolve_only(1, 30'h140);

        // Target mispredict with both taken
        push_only(10'd9, 1, 30'h200, 30'h101);
        resolve_only(1, 30'h204);

        // Mispredict counter saturation
        @(negedge Clk);
        dut.mispredicts_q = 16'hFFFE;
        m_mis = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            push_only(10'(50 + i), 0, 30'h10, 30'h300);
            resolve_only(1, 30'(30'h400 + i));
        end

        // Reset in the cycle following a resolve, and reset coincident with a resolve
        push_only(10'd11, 1, 30'h500, 30'h501);
        resolve_only(0, 30'h0);
        step(1, 0, '0, 0, '0, '0, 0, 0, '0);
        step(0, 1, 10'd12, 1, 30'h600, 30'h601, 0, 0, '0);
        step(1, 0, '0, 0, '0, '0, 1, 1, 30'h600);

        // Random mix
        for (int i = 0; i < 60; i++) begin
            step(0, $urandom_range(0, 1) == 1, 10'($urandom), $urandom_range(0, 1) == 1,
                 30'($urandom_range(0, 3)), 30'($urandom_range(8, 11)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 30'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
